pipe_stage_buf: RTL and testbench
=================================

# pipe_stage_buf

Parametrised pipeline stage register for the RV32I pipeline. It replaces the fixed per-stage registers with one generic block carrying a control bundle and a data bundle. It adds a valid/ready handshake, a synchronous flush that inserts bubbles, and an optional skid entry that makes the stage full-throughput with a registered upstream ready. One instance sits between each pair of stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

## Interface

Parameters:

- `CTRL_W`, default 3: width of the control bundle (e.g. mem_rd, reg_wr, mux_reg_wr). Forced to zero in bubbles.
- `DATA_W`, default 69: width of the data bundle (e.g. ula_res 32 + mem_res 32 + rd 5).
- `SKID`, default 1:
  - 1 = two-entry skid buffer, `in_ready` registered.
  - 0 = single entry, `in_ready` combinational.

Ports:

- `clk` in 1: single clock. All state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous kill of all held and incoming entries.
- `in_valid` in 1: upstream entry present.
- `in_ready` out 1: stage can accept this cycle.
- `in_ctrl` in CTRL_W: upstream control bundle.
- `in_data` in DATA_W: upstream data bundle.
- `out_valid` out 1: head entry present.
- `out_ready` in 1: downstream accepts head.
- `out_ctrl` out CTRL_W: head control; all-zero when `out_valid`=0.
- `out_data` out DATA_W: head data; last loaded value when invalid.
- `count` out 2: entries held (0..2; max 1 when SKID=0).

## Operation

- Accept when `in_valid && in_ready`. Pop when `out_valid && out_ready`.
- Order is strict FIFO. No entry is duplicated or dropped except by `flush`.
- States (SKID=1): EMPTY, ONE (main valid), TWO (main + skid valid).
  - EMPTY: accept → ONE.
  - ONE: accept without pop → TWO, new entry goes to skid. Pop without accept → EMPTY. Accept with pop → ONE, main reloaded.
  - TWO: `in_ready`=0. Pop → ONE, skid moves to main.
- SKID=0: states EMPTY and ONE only. `in_ready = !out_valid || out_ready`.
- SKID=1: `in_ready = (state != TWO)`, driven from a flop.
- Flush:
  - Next state is EMPTY. Ctrl of both entries is cleared to 0; data is held.
  - A handshake in the same cycle is discarded and is not counted.
  - Flush wins over accept and pop.
- Bubble gating: `out_ctrl` is forced to 0 whenever `out_valid`=0, so consumers that ignore valid never see a write enable.
- `count` = number of valid entries, taken from the state.

## Timing

- Reset (`rst_n`=0, asynchronous):
  - State EMPTY; `out_valid`=0, `out_ctrl`=0, `out_data`=0, `count`=0.
  - `in_ready`=1 once reset deasserts. While in reset, `in_ready`=1 for SKID=1 and is combinational for SKID=0.
- Latency: an entry accepted at edge N is visible at `out_*` after edge N. Minimum latency is 1 cycle.
- Throughput: 1 entry/cycle with continuous `out_ready` in both modes.
- SKID=1 backpressure response:
  - `out_ready` falling costs no entry.
  - `in_ready` falls 1 cycle after the skid fills and rises in the cycle after the pop that empties the skid.
- No combinational path exists from `out_ready` to `in_ready` when SKID=1.
- Reset asserted mid-transfer: all entries are discarded immediately and the outputs take their reset values asynchronously.
- `out_data` and `out_ctrl` are stable while `out_valid && !out_ready`.

## Structure

- Package `pipe_pkg` holds:
  - The state enum (EMPTY, ONE, TWO).
  - Default width constants for each stage's bundle (IF_ID_CTRL_W, MEM_WB_DATA_W, ...).
- Sub-module `pipe_slot` holds one valid+ctrl+data register, with load, clear-ctrl, and async active-low reset. It is instantiated as main and skid; only main exists when SKID=0.
- The top level holds the state flop, the ready logic, the mux that feeds main from input or skid, and the output gating.

## Test plan

- **Reset:** hold `rst_n`=0 with `in_valid`=1 and `in_ctrl`=3'b111 → `out_valid`=0, `out_ctrl`=0, `out_data`=0, `count`=0. After release, `in_ready`=1.
- **Streaming (SKID=1):** 8 entries with `data`=0..7 and `ctrl`=3'b010, `out_ready`=1 → output 0..7 on consecutive cycles, 1-cycle latency, `count`=1 throughout.
- **Backpressure (SKID=1):**
  - `out_ready`=0 while sending A and B → `count`=2 and `in_ready`=0 on the next cycle; C is held upstream.
  - `out_ready`=1 → A, B, C emerge in order with none lost.
- **Flush with simultaneous accept:**
  - TWO state plus `flush`=1 with `in_valid`=1 → `count`=0, `out_valid`=0, `out_ctrl`=0 next cycle; the incoming entry never appears.
- **Bubble gating:** accept `ctrl`=3'b111 and pop it with no new input → `out_ctrl`=0 while `out_data` still shows the old value.
- **SKID=0:** with `out_ready`=0 and one entry held → `in_ready`=0 in the same cycle. Raising `out_ready` → `in_ready`=1 combinationally and a pop plus accept occur in the same cycle.

Source files
------------

// File: rtl/pipe_stage_buf_pkg.sv
// rtl/pipe_stage_buf_pkg.sv - shared types and bundle widths for the pipeline stage buffer
//
// Purpose: occupancy state enum, per-stage default bundle widths and a
// helper that turns the occupancy state into an entry count.
// Ports: none (package).
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_e;

  // IF/ID: pc 32 + instr 32; single control bit (entry is a real fetch)
  localparam int IF_ID_CTRL_W  = 1;
  localparam int IF_ID_DATA_W  = 64;
  // ID/EX: rs1 32 + rs2 32 + imm 32 + rd 5; alu op / mem / wb controls
  localparam int ID_EX_CTRL_W  = 8;
  localparam int ID_EX_DATA_W  = 101;
  // EX/MEM: ula_res 32 + store data 32 + rd 5
  localparam int EX_MEM_CTRL_W = 3;
  localparam int EX_MEM_DATA_W = 69;
  // MEM/WB: ula_res 32 + mem_res 32 + rd 5; mem_rd, reg_wr, mux_reg_wr
  localparam int MEM_WB_CTRL_W = 3;
  localparam int MEM_WB_DATA_W = 69;

  function automatic logic [1:0] state_count(input pipe_state_e st);
    case (st)
      ONE:     state_count = 2'd1;
      TWO:     state_count = 2'd2;
      default: state_count = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_buf_if.sv
// rtl/pipe_stage_buf_if.sv - handshake bundle between a pipeline stage buffer and its neighbours
//
// Purpose: groups flush, the upstream (in_*) and downstream (out_*) handshakes
// and the occupancy count of one stage buffer.
// Modports:
//   slave  - the stage buffer: consumes in_*/out_ready/flush, drives the rest
//   master - the surrounding pipeline: drives in_*/out_ready/flush
interface pipe_stage_buf_if #(
  parameter int CTRL_W = 3,
  parameter int DATA_W = 69
) ();

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        count;

  modport slave (
    input  flush, in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data, count
  );

  modport master (
    output flush, in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data, count
  );

endinterface

// File: rtl/pipe_stage_buf_slot.sv
// rtl/pipe_stage_buf_slot.sv - one valid+ctrl+data entry register
//
// Purpose: a single buffer entry. clr drops the entry and zeroes its control
// bundle while keeping the data; load captures a new entry. clr wins.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   load, clr         - capture d_* / invalidate and zero ctrl
//   d_ctrl, d_data    - entry to capture
//   q_valid, q_ctrl, q_data - held entry
module pipe_slot #(
  parameter int CTRL_W = 3,
  parameter int DATA_W = 69
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clr,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic              q_valid,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [DATA_W-1:0] q_data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_valid <= 1'b0;
      q_ctrl  <= '0;
      q_data  <= '0;
    end else if (clr) begin
      q_valid <= 1'b0;
      q_ctrl  <= '0;
    end else if (load) begin
      q_valid <= 1'b1;
      q_ctrl  <= d_ctrl;
      q_data  <= d_data;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - generic valid/ready pipeline stage register with optional skid entry
//
// Purpose: FIFO-ordered stage register carrying a control and a data bundle,
// with synchronous flush (bubble insertion) and bubble gating of out_ctrl.
// SKID=1 adds a second entry so in_ready can come straight from a flop.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - pipe_stage_buf_if.slave: flush, in_* (upstream),
//                out_* (downstream), count (entries held)
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 3,
  parameter int DATA_W = 69,
  parameter bit SKID   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipe_stage_buf_if.slave      bus
);

  pipe_state_e       state_q, state_d;

  logic              main_valid, skid_valid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_d_ctrl;
  logic [DATA_W-1:0] main_data, skid_data, main_d_data;
  logic              main_load, main_clr, skid_load, skid_clr;
  logic              in_ready, accept, pop;

  assign accept = bus.in_valid && in_ready;
  assign pop    = main_valid && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // With SKID=0, in ONE an accept always comes with a pop, so TWO is unreachable.
  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
    main_clr  = 1'b0;
    skid_load = 1'b0;
    skid_clr  = 1'b0;
    if (bus.flush) begin
      state_d  = EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d   = ONE;
            main_load = 1'b1;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_load = 1'b1;
          end else if (accept) begin
            state_d   = TWO;
            skid_load = 1'b1;
          end else if (pop) begin
            state_d  = EMPTY;
            main_clr = 1'b1;
          end
        end
        TWO: begin
          if (pop) begin
            state_d   = ONE;
            main_load = 1'b1;
            skid_clr  = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Main refills from the skid whenever the skid holds the older entry.
  assign main_d_ctrl = skid_valid ? skid_ctrl : bus.in_ctrl;
  assign main_d_data = skid_valid ? skid_data : bus.in_data;

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (main_load),
    .clr     (main_clr),
    .d_ctrl  (main_d_ctrl),
    .d_data  (main_d_data),
    .q_valid (main_valid),
    .q_ctrl  (main_ctrl),
    .q_data  (main_data)
  );

  if (SKID) begin : g_skid
    logic in_ready_q;

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (skid_load),
      .clr     (skid_clr),
      .d_ctrl  (bus.in_ctrl),
      .d_data  (bus.in_data),
      .q_valid (skid_valid),
      .q_ctrl  (skid_ctrl),
      .q_data  (skid_data)
    );

    // Registered ready: decoupled from out_ready, looks at the next state.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) in_ready_q <= 1'b1;
      else        in_ready_q <= (state_d != TWO);
    end

    assign in_ready = in_ready_q;
  end else begin : g_noskid
    assign skid_valid = 1'b0;
    assign skid_ctrl  = '0;
    assign skid_data  = '0;
    assign in_ready   = !main_valid || bus.out_ready;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = main_valid;
  // Consumers that ignore valid must never see a stale write enable.
  assign bus.out_ctrl  = main_valid ? main_ctrl : '0;
  assign bus.out_data  = main_data;
  assign bus.count     = state_count(state_q);

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - directed self-checking bench for pipe_stage_buf
module tb_pipe_stage_buf;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipe_stage_buf_if #(.CTRL_W(3), .DATA_W(69)) b1 ();
  pipe_stage_buf_if #(.CTRL_W(3), .DATA_W(69)) b0 ();

  pipe_stage_buf #(.CTRL_W(3), .DATA_W(69), .SKID(1'b1)) u_skid1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1)
  );

  pipe_stage_buf #(.CTRL_W(3), .DATA_W(69), .SKID(1'b0)) u_skid0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    b1.flush = 1'b0; b1.in_valid = 1'b1; b1.in_ctrl = 3'b111;
    b1.in_data = 69'h1F; b1.out_ready = 1'b0;
    b0.flush = 1'b0; b0.in_valid = 1'b1; b0.in_ctrl = 3'b111;
    b0.in_data = 69'h1F; b0.out_ready = 1'b0;
    tick();
    tick();
    checks++; if (b1.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", b1.out_valid); end
    checks++; if (b1.out_ctrl !== 3'b000) begin errors++; $display("FAIL reset_out_ctrl got %0b want 000", b1.out_ctrl); end
    checks++; if (b1.out_data !== 69'h0) begin errors++; $display("FAIL reset_out_data got %0h want 0", b1.out_data); end
    checks++; if (b1.count !== 2'd0) begin errors++; $display("FAIL reset_count got %0d want 0", b1.count); end
    checks++; if (b1.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_skid1 got %0b want 1", b1.in_ready); end
    checks++; if (b0.out_valid !== 1'b0) begin errors++; $display("FAIL reset_skid0_out_valid got %0b want 0", b0.out_valid); end
    checks++; if (b0.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_skid0 got %0b want 1", b0.in_ready); end
    b1.in_valid = 1'b0; b1.in_ctrl = 3'b000; b1.out_ready = 1'b1;
    b0.in_valid = 1'b0; b0.in_ctrl = 3'b000; b0.out_ready = 1'b1;
    rst_n = 1'b1;
    tick();
    checks++; if (b1.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %0b want 1", b1.in_ready); end
    checks++; if (b1.count !== 2'd0) begin errors++; $display("FAIL post_reset_count got %0d want 0", b1.count); end
  endtask

  task automatic test_streaming();
    b1.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b1.in_valid = 1'b1; b1.in_ctrl = 3'b010; b1.in_data = 69'(i);
      tick();
      checks++; if (b1.out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %0b want 1", i, b1.out_valid); end
      checks++; if (b1.out_data !== 69'(i)) begin errors++; $display("FAIL stream_data[%0d] got %0h want %0h", i, b1.out_data, i); end
      checks++; if (b1.out_ctrl !== 3'b010) begin errors++; $display("FAIL stream_ctrl[%0d] got %0b want 010", i, b1.out_ctrl); end
      checks++; if (b1.count !== 2'd1) begin errors++; $display("FAIL stream_count[%0d] got %0d want 1", i, b1.count); end
      checks++; if (b1.in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d] got %0b want 1", i, b1.in_ready); end
    end
    b1.in_valid = 1'b0;
    tick();
    checks++; if (b1.out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain_valid got %0b want 0", b1.out_valid); end
    checks++; if (b1.count !== 2'd0) begin errors++; $display("FAIL stream_drain_count got %0d want 0", b1.count); end
  endtask

  task automatic test_backpressure();
    b1.out_ready = 1'b0;
    b1.in_valid = 1'b1; b1.in_ctrl = 3'b010; b1.in_data = 69'hA;
    tick();
    checks++; if (b1.count !== 2'd1) begin errors++; $display("FAIL bp_a_count got %0d want 1", b1.count); end
    checks++; if (b1.in_ready !== 1'b1) begin errors++; $display("FAIL bp_a_in_ready got %0b want 1", b1.in_ready); end
    b1.in_data = 69'hB;
    tick();
    checks++; if (b1.count !== 2'd2) begin errors++; $display("FAIL bp_b_count got %0d want 2", b1.count); end
    checks++; if (b1.in_ready !== 1'b0) begin errors++; $display("FAIL bp_b_in_ready got %0b want 0", b1.in_ready); end
    checks++; if (b1.out_data !== 69'hA) begin errors++; $display("FAIL bp_b_head got %0h want a", b1.out_data); end
    b1.in_data = 69'hC;
    tick();
    checks++; if (b1.count !== 2'd2) begin errors++; $display("FAIL bp_c_held_count got %0d want 2", b1.count); end
    checks++; if (b1.out_data !== 69'hA) begin errors++; $display("FAIL bp_head_stable got %0h want a", b1.out_data); end
    b1.out_ready = 1'b1;
    tick();
    checks++; if (b1.out_data !== 69'hB) begin errors++; $display("FAIL bp_order_b got %0h want b", b1.out_data); end
    checks++; if (b1.count !== 2'd1) begin errors++; $display("FAIL bp_pop_count got %0d want 1", b1.count); end
    checks++; if (b1.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_rise got %0b want 1", b1.in_ready); end
    tick();
    checks++; if (b1.out_data !== 69'hC) begin errors++; $display("FAIL bp_order_c got %0h want c", b1.out_data); end
    checks++; if (b1.out_valid !== 1'b1) begin errors++; $display("FAIL bp_c_valid got %0b want 1", b1.out_valid); end
    b1.in_valid = 1'b0;
    tick();
    checks++; if (b1.count !== 2'd0) begin errors++; $display("FAIL bp_drain_count got %0d want 0", b1.count); end
  endtask

  task automatic test_flush();
    b1.out_ready = 1'b0;
    b1.in_valid = 1'b1; b1.in_ctrl = 3'b011; b1.in_data = 69'hD;
    tick();
    b1.in_data = 69'hE;
    tick();
    checks++; if (b1.count !== 2'd2) begin errors++; $display("FAIL flush_setup_count got %0d want 2", b1.count); end
    b1.flush = 1'b1; b1.in_ctrl = 3'b111; b1.in_data = 69'hF;
    tick();
    checks++; if (b1.count !== 2'd0) begin errors++; $display("FAIL flush_count got %0d want 0", b1.count); end
    checks++; if (b1.out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b want 0", b1.out_valid); end
    checks++; if (b1.out_ctrl !== 3'b000) begin errors++; $display("FAIL flush_ctrl got %0b want 000", b1.out_ctrl); end
    checks++; if (b1.out_data !== 69'hD) begin errors++; $display("FAIL flush_data_held got %0h want d", b1.out_data); end
    checks++; if (b1.in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %0b want 1", b1.in_ready); end
    b1.flush = 1'b0; b1.in_valid = 1'b0; b1.out_ready = 1'b1;
    tick();
    checks++; if (b1.out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_ghost got %0b want 0", b1.out_valid); end
  endtask

  task automatic test_bubble();
    b1.out_ready = 1'b1;
    b1.in_valid = 1'b1; b1.in_ctrl = 3'b111; b1.in_data = 69'h55;
    tick();
    checks++; if (b1.out_ctrl !== 3'b111) begin errors++; $display("FAIL bubble_live_ctrl got %0b want 111", b1.out_ctrl); end
    b1.in_valid = 1'b0; b1.in_ctrl = 3'b000;
    tick();
    checks++; if (b1.out_valid !== 1'b0) begin errors++; $display("FAIL bubble_valid got %0b want 0", b1.out_valid); end
    checks++; if (b1.out_ctrl !== 3'b000) begin errors++; $display("FAIL bubble_ctrl got %0b want 000", b1.out_ctrl); end
    checks++; if (b1.out_data !== 69'h55) begin errors++; $display("FAIL bubble_data got %0h want 55", b1.out_data); end
  endtask

  task automatic test_skid0();
    b0.out_ready = 1'b0;
    b0.in_valid = 1'b1; b0.in_ctrl = 3'b001; b0.in_data = 69'h11;
    tick();
    checks++; if (b0.out_valid !== 1'b1) begin errors++; $display("FAIL s0_valid got %0b want 1", b0.out_valid); end
    checks++; if (b0.count !== 2'd1) begin errors++; $display("FAIL s0_count got %0d want 1", b0.count); end
    checks++; if (b0.in_ready !== 1'b0) begin errors++; $display("FAIL s0_in_ready_low got %0b want 0", b0.in_ready); end
    b0.in_data = 69'h22; b0.in_ctrl = 3'b100;
    tick();
    checks++; if (b0.out_data !== 69'h11) begin errors++; $display("FAIL s0_head_stable got %0h want 11", b0.out_data); end
    b0.out_ready = 1'b1;
    #1;
    checks++; if (b0.in_ready !== 1'b1) begin errors++; $display("FAIL s0_in_ready_comb got %0b want 1", b0.in_ready); end
    tick();
    checks++; if (b0.out_data !== 69'h22) begin errors++; $display("FAIL s0_pop_accept_data got %0h want 22", b0.out_data); end
    checks++; if (b0.out_ctrl !== 3'b100) begin errors++; $display("FAIL s0_pop_accept_ctrl got %0b want 100", b0.out_ctrl); end
    checks++; if (b0.count !== 2'd1) begin errors++; $display("FAIL s0_pop_accept_count got %0d want 1", b0.count); end
    b0.in_valid = 1'b0;
    tick();
    checks++; if (b0.out_valid !== 1'b0) begin errors++; $display("FAIL s0_drain_valid got %0b want 0", b0.out_valid); end
    checks++; if (b0.count !== 2'd0) begin errors++; $display("FAIL s0_drain_count got %0d want 0", b0.count); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_bubble();
    test_skid0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
